fsm_esteira: RTL and testbench

FSM_ESTEIRA -- requirements
Module: fsm_esteira

---
 rtl/fsm_esteira.sv | 124 ++++++++++++
 tb/tb_fsm_esteira.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fsm_esteira.sv
// Conveyor-belt move controller: runs the motor until a station sensor edge, a master abort or a timeout.
// Optional move timeout and ERRO state enabled by defining ESTEIRA_TIMEOUT_EN.
module fsm_esteira #(
    parameter int unsigned TIMEOUT_CICLOS = 250000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_mover_esteira,
    input  logic       sensor_enchimento,
    input  logic       sensor_cq,
    input  logic       sensor_final,
    output logic       motor_ligado,
    output logic       esteira_concluida,
    output logic [1:0] posicao,
    output logic       alarme_esteira
);

    localparam int unsigned N_SENS = 3;
    localparam int unsigned CNT_W  = 28;

    typedef enum logic [1:0] {
        PARADO    = 2'd0,
        MOVENDO   = 2'd1,
        CONCLUIDO = 2'd2,
        ERRO      = 2'd3
    } estado_t;

    // The timeout must be reachable by the 28-bit counter.
    if (TIMEOUT_CICLOS < 2 || TIMEOUT_CICLOS > 268435456) begin : g_timeout_range
        $error("TIMEOUT_CICLOS out of range");
    end

    estado_t             estado_q, estado_d;
    logic [1:0]          posicao_q, posicao_d;
    logic [N_SENS-1:0]   sync1_q, sync2_q, sync3_q;
    logic [N_SENS-1:0]   sens;
    logic [N_SENS-1:0]   rise;
`ifdef ESTEIRA_TIMEOUT_EN
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                timeout;
`endif

    // Sensor bit order: {final, cq, enchimento}.
    assign sens = {sensor_final, sensor_cq, sensor_enchimento};
    assign rise = sync2_q & ~sync3_q;

`ifdef ESTEIRA_TIMEOUT_EN
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CICLOS - 1));
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            estado_q  <= PARADO;
            posicao_q <= 2'd0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            sync3_q   <= '0;
`ifdef ESTEIRA_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            estado_q  <= estado_d;
            posicao_q <= posicao_d;
            sync1_q   <= sens;
            sync2_q   <= sync1_q;
            sync3_q   <= sync2_q;
`ifdef ESTEIRA_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    // Abort beats a sensor edge, which beats the timeout.
    always_comb begin
        estado_d  = estado_q;
        posicao_d = posicao_q;
`ifdef ESTEIRA_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (estado_q)
            PARADO: begin
                if (cmd_mover_esteira) begin
                    estado_d = MOVENDO;
`ifdef ESTEIRA_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
            end
            MOVENDO: begin
`ifdef ESTEIRA_TIMEOUT_EN
                cnt_d = cnt_q + CNT_W'(1);
`endif
                if (!cmd_mover_esteira) begin
                    estado_d = PARADO;
                end else if (|rise) begin
                    estado_d = CONCLUIDO;
                    if (rise[2])      posicao_d = 2'd3;
                    else if (rise[1]) posicao_d = 2'd2;
                    else              posicao_d = 2'd1;
                end
`ifdef ESTEIRA_TIMEOUT_EN
                else if (timeout) begin
                    estado_d = ERRO;
                end
`endif
            end
            CONCLUIDO: begin
                if (!cmd_mover_esteira) estado_d = PARADO;
            end
            ERRO:    estado_d = ERRO;
            default: estado_d = PARADO;
        endcase
    end

    assign motor_ligado      = (estado_q == MOVENDO);
    assign esteira_concluida = (estado_q == CONCLUIDO);
    assign posicao           = posicao_q;
`ifdef ESTEIRA_TIMEOUT_EN
    assign alarme_esteira    = (estado_q == ERRO);
`else
    assign alarme_esteira    = 1'b0;
`endif

endmodule

// File: tb/tb_fsm_esteira.sv
// Directed self-checking bench for fsm_esteira with TIMEOUT_CICLOS=20.
module tb_fsm_esteira;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cmd_mover_esteira;
    logic       sensor_enchimento;
    logic       sensor_cq;
    logic       sensor_final;
    logic       motor_ligado;
    logic       esteira_concluida;
    logic [1:0] posicao;
    logic       alarme_esteira;

    int n_chk  = 0;
    int n_pass = 0;
    logic saw_concl;

    fsm_esteira #(.TIMEOUT_CICLOS(20)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .cmd_mover_esteira (cmd_mover_esteira),
        .sensor_enchimento (sensor_enchimento),
        .sensor_cq         (sensor_cq),
        .sensor_final      (sensor_final),
        .motor_ligado      (motor_ligado),
        .esteira_concluida (esteira_concluida),
        .posicao           (posicao),
        .alarme_esteira    (alarme_esteira)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One rising edge, then settle before sampling or driving.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_clear();
        cmd_mover_esteira = 1'b0;
        sensor_enchimento = 1'b0;
        sensor_cq         = 1'b0;
        sensor_final      = 1'b0;
        step(4);
    endtask

    initial begin
        reset_n = 1'b0;
        cmd_mover_esteira = 1'b0;
        sensor_enchimento = 1'b0;
        sensor_cq = 1'b0;
        sensor_final = 1'b0;
        step(2);
        chk("rst_motor", 32'(motor_ligado), 32'd0);
        chk("rst_concl", 32'(esteira_concluida), 32'd0);
        chk("rst_pos", 32'(posicao), 32'd0);
        chk("rst_alarm", 32'(alarme_esteira), 32'd0);
        reset_n = 1'b1;
        step(1);

        // Normal move stopping at cq.
        cmd_mover_esteira = 1'b1;
        step(1);
        chk("norm_start", 32'(motor_ligado), 32'd1);
        step(4);
        sensor_cq = 1'b1;
        step(1);
        chk("norm_n", 32'(motor_ligado), 32'd1);
        step(1);
        chk("norm_n1", 32'(motor_ligado), 32'd1);
        step(1);
        chk("norm_n2_motor", 32'(motor_ligado), 32'd0);
        chk("norm_n2_concl", 32'(esteira_concluida), 32'd1);
        chk("norm_pos", 32'(posicao), 32'd2);
        step(2);
        chk("norm_hold", 32'(esteira_concluida), 32'd1);
        cmd_mover_esteira = 1'b0;
        step(1);
        chk("norm_drop", 32'(esteira_concluida), 32'd0);
        idle_clear();

        // Simultaneous cq and final edges: final wins.
        cmd_mover_esteira = 1'b1;
        step(3);
        sensor_cq = 1'b1;
        sensor_final = 1'b1;
        step(3);
        chk("simul_concl", 32'(esteira_concluida), 32'd1);
        chk("simul_pos", 32'(posicao), 32'd3);
        idle_clear();

        // Enchimento edge alone.
        cmd_mover_esteira = 1'b1;
        step(2);
        sensor_enchimento = 1'b1;
        step(3);
        chk("ench_pos", 32'(posicao), 32'd1);
        idle_clear();

        // Pre-set enchimento is ignored; later final edge stops the belt.
        sensor_enchimento = 1'b1;
        step(4);
        cmd_mover_esteira = 1'b1;
        step(6);
        chk("preset_motor", 32'(motor_ligado), 32'd1);
        chk("preset_pos", 32'(posicao), 32'd1);
        sensor_final = 1'b1;
        step(2);
        chk("preset_n1", 32'(motor_ligado), 32'd1);
        step(1);
        chk("preset_concl", 32'(esteira_concluida), 32'd1);
        chk("preset_pos3", 32'(posicao), 32'd3);
        idle_clear();

        // Plain abort after 4 cycles of command.
        saw_concl = 1'b0;
        cmd_mover_esteira = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            saw_concl |= esteira_concluida;
        end
        cmd_mover_esteira = 1'b0;
        step(1);
        saw_concl |= esteira_concluida;
        chk("abort_motor", 32'(motor_ligado), 32'd0);
        step(2);
        saw_concl |= esteira_concluida;
        chk("abort_concl", 32'(saw_concl), 32'd0);
        chk("abort_pos", 32'(posicao), 32'd3);

        // Abort sampled on the same edge as a cq edge: abort wins.
        cmd_mover_esteira = 1'b1;
        step(3);
        sensor_cq = 1'b1;
        step(2);
        cmd_mover_esteira = 1'b0;
        step(1);
        chk("abort_edge_motor", 32'(motor_ligado), 32'd0);
        chk("abort_edge_concl", 32'(esteira_concluida), 32'd0);
        step(1);
        chk("abort_edge_late", 32'(esteira_concluida), 32'd0);
        chk("abort_edge_pos", 32'(posicao), 32'd3);
        idle_clear();

        // Timeout behaviour.
        cmd_mover_esteira = 1'b1;
        step(1);
`ifdef ESTEIRA_TIMEOUT_EN
        step(19);
        chk("to_before_motor", 32'(motor_ligado), 32'd1);
        chk("to_before_alarm", 32'(alarme_esteira), 32'd0);
        step(1);
        chk("to_motor", 32'(motor_ligado), 32'd0);
        chk("to_alarm", 32'(alarme_esteira), 32'd1);
        cmd_mover_esteira = 1'b0;
        step(2);
        cmd_mover_esteira = 1'b1;
        step(2);
        cmd_mover_esteira = 1'b0;
        step(2);
        chk("to_hold_alarm", 32'(alarme_esteira), 32'd1);
        chk("to_hold_motor", 32'(motor_ligado), 32'd0);
        reset_n = 1'b0;
        step(1);
        chk("to_reset_alarm", 32'(alarme_esteira), 32'd0);
        reset_n = 1'b1;
        step(1);
`else
        step(120);
        chk("noto_motor", 32'(motor_ligado), 32'd1);
        chk("noto_alarm", 32'(alarme_esteira), 32'd0);
        cmd_mover_esteira = 1'b0;
        step(1);
        chk("noto_abort", 32'(motor_ligado), 32'd0);
`endif
        idle_clear();

        // Reset mid-move, then restart with command still high.
        cmd_mover_esteira = 1'b1;
        step(3);
        chk("mid_moving", 32'(motor_ligado), 32'd1);
        reset_n = 1'b0;
        step(1);
        chk("mid_rst_motor", 32'(motor_ligado), 32'd0);
        chk("mid_rst_pos", 32'(posicao), 32'd0);
        reset_n = 1'b1;
        step(1);
        chk("mid_restart", 32'(motor_ligado), 32'd1);
        idle_clear();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
